// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester memory port arbiter.
package mem_port_arbiter_pkg;

    // Arbiter FSM: idle, or waiting for a read response to come back.
    typedef enum logic {
        ARB_IDLE    = 1'b0,
        ARB_RD_WAIT = 1'b1
    } arb_state_e;

    // Requester identity, used to route read data to its owner.
    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } req_id_e;

    // Legal ranges of the tuning parameters.
    localparam int RD_LAT_MIN       = 1;
    localparam int RD_LAT_MAX       = 4;
    localparam int STARVE_LIMIT_MIN = 1;
    localparam int STARVE_LIMIT_MAX = 15;

    // Force a parameter into its legal range so counters never overflow.
    function automatic int clamp_range(input int value, input int lo, input int hi);
        if (value < lo) begin
            return lo;
        end else if (value > hi) begin
            return hi;
        end else begin
            return value;
        end
    endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_pick.sv
// D-priority picker with an anti-starvation override for instruction fetch.
module mem_port_arbiter_arb_pick
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic arb_en,
    input  logic i_req,
    input  logic d_req,
    output logic grant_i,
    output logic grant_d
);

    localparam logic [3:0] LIMIT_C =
        4'(clamp_range(STARVE_LIMIT, STARVE_LIMIT_MIN, STARVE_LIMIT_MAX));

    logic [3:0] starve_cnt_r;
    logic       starved_s;

    // Pick the winner: D first, unless I has lost LIMIT_C contested rounds in a row.
    always_comb begin
        starved_s = (starve_cnt_r == LIMIT_C);
        grant_i   = 1'b0;
        grant_d   = 1'b0;
        if (arb_en) begin
            if (d_req && !(i_req && starved_s)) begin
                grant_d = 1'b1;
            end else if (i_req) begin
                grant_i = 1'b1;
            end else begin
                grant_i = 1'b0;
                grant_d = 1'b0;
            end
        end else begin
            grant_i = 1'b0;
            grant_d = 1'b0;
        end
    end

    // Count consecutive D wins over a waiting I; any I grant clears the streak.
    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt_r <= 4'd0;
        end else if (grant_i) begin
            starve_cnt_r <= 4'd0;
        end else if (grant_d && i_req && (starve_cnt_r != LIMIT_C)) begin
            starve_cnt_r <= starve_cnt_r + 4'd1;
        end else begin
            starve_cnt_r <= starve_cnt_r;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one synchronous memory port between instruction fetch (I) and data (D).
// Tracks the single outstanding read and routes its data back to the owner.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int AW           = 32,
    parameter int DW           = 32,
    parameter int RD_LAT       = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          busy
);

    localparam logic [2:0] RD_LAT_C = 3'(clamp_range(RD_LAT, RD_LAT_MIN, RD_LAT_MAX));

    arb_state_e state_r, state_nxt_s;
    req_id_e    owner_r, owner_nxt_s;
    logic [2:0] lat_cnt_r, lat_cnt_nxt_s;
    logic       arb_en_s;
    logic       resp_s;
    logic       grant_i_s;
    logic       grant_d_s;
    logic       rd_grant_s;

    // Arbitration opens when idle or in the last cycle of a read; reset closes it.
    always_comb begin
        arb_en_s = 1'b0;
        resp_s   = 1'b0;
        if (reset) begin
            arb_en_s = 1'b0;
            resp_s   = 1'b0;
        end else if (state_r == ARB_RD_WAIT) begin
            resp_s   = (lat_cnt_r == 3'd1);
            arb_en_s = (lat_cnt_r == 3'd1);
        end else begin
            resp_s   = 1'b0;
            arb_en_s = 1'b1;
        end
    end

    mem_port_arbiter_arb_pick #(
        .STARVE_LIMIT(STARVE_LIMIT)
    ) u_arb_pick (
        .clk    (clk),
        .reset  (reset),
        .arb_en (arb_en_s),
        .i_req  (i_req),
        .d_req  (d_req),
        .grant_i(grant_i_s),
        .grant_d(grant_d_s)
    );

    // Drive the memory port from the winner; an idle bus is all zeros.
    always_comb begin
        mem_addr  = {AW{1'b0}};
        mem_we    = 1'b0;
        mem_wdata = {DW{1'b0}};
        if (grant_d_s) begin
            mem_addr  = d_addr;
            mem_we    = d_we;
            mem_wdata = d_wdata;
        end else if (grant_i_s) begin
            mem_addr  = i_addr;
            mem_we    = 1'b0;
            mem_wdata = {DW{1'b0}};
        end else begin
            mem_addr  = {AW{1'b0}};
            mem_we    = 1'b0;
            mem_wdata = {DW{1'b0}};
        end
    end

    // Grants, response routing and busy flag; read data is a plain pass-through.
    always_comb begin
        i_gnt      = grant_i_s;
        d_gnt      = grant_d_s;
        rd_grant_s = grant_i_s || (grant_d_s && !d_we);
        i_rvalid   = resp_s && (owner_r == REQ_I);
        d_rvalid   = resp_s && (owner_r == REQ_D);
        i_rdata    = mem_rdata;
        d_rdata    = mem_rdata;
        busy       = !reset && (state_r == ARB_RD_WAIT);
    end

    // Next state: a new read restarts the countdown, otherwise count down to idle.
    always_comb begin
        state_nxt_s   = state_r;
        owner_nxt_s   = owner_r;
        lat_cnt_nxt_s = lat_cnt_r;
        if (rd_grant_s) begin
            state_nxt_s   = ARB_RD_WAIT;
            lat_cnt_nxt_s = RD_LAT_C;
            owner_nxt_s   = grant_d_s ? REQ_D : REQ_I;
        end else if ((state_r == ARB_RD_WAIT) && (lat_cnt_r > 3'd1)) begin
            state_nxt_s   = ARB_RD_WAIT;
            lat_cnt_nxt_s = lat_cnt_r - 3'd1;
        end else begin
            state_nxt_s   = ARB_IDLE;
            lat_cnt_nxt_s = 3'd0;
        end
    end

    // State register; reset drops any pending read.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ARB_IDLE;
            owner_r   <= REQ_I;
            lat_cnt_r <= 3'd0;
        end else begin
            state_r   <= state_nxt_s;
            owner_r   <= owner_nxt_s;
            lat_cnt_r <= lat_cnt_nxt_s;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus randomized
// traffic checked against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int LAT   = 3;
    localparam int LIMIT = 4;

    logic        clk;
    logic        reset;
    logic        i_req, d_req, d_we;
    logic [31:0] i_addr, d_addr, d_wdata, mem_rdata;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, mem_we, busy;
    logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;

    int n_cmp = 0;
    int n_err = 0;

    mem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(LAT), .STARVE_LIMIT(LIMIT)) u_dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory contents are a fixed function of the address.
    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a ^ 32'hA5A5_0F0F) + {a[15:0], a[31:16]};
    endfunction

    // Memory with LAT cycles of read latency.
    logic [31:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= mem_addr;
        for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign mem_rdata = rom(pipe[LAT-1]);

    // Reference model: absolute cycle at which the pending read answers.
    int          cyc = 0;
    int          resp_cyc = -1;
    logic        resp_own_d = 1'b0;
    logic [31:0] resp_addr = 32'h0;
    int          streak = 0;
    logic        e_i_gnt, e_d_gnt, e_i_rv, e_d_rv, e_busy, e_mem_we;
    logic [31:0] e_rdata, e_mem_addr, e_mem_wdata;

    always_comb begin
        e_i_gnt = 1'b0; e_d_gnt = 1'b0; e_i_rv = 1'b0; e_d_rv = 1'b0;
        e_busy = 1'b0; e_mem_we = 1'b0; e_mem_addr = 32'h0; e_mem_wdata = 32'h0;
        e_rdata = rom(resp_addr);
        if (!reset) begin
            e_busy  = (resp_cyc >= 0);
            e_i_rv  = (resp_cyc == cyc) && !resp_own_d;
            e_d_rv  = (resp_cyc == cyc) && resp_own_d;
            if (resp_cyc < 0 || resp_cyc == cyc) begin
                e_d_gnt = d_req && !(i_req && streak == LIMIT);
                e_i_gnt = i_req && !e_d_gnt;
            end
            if (e_d_gnt) begin
                e_mem_addr = d_addr; e_mem_we = d_we; e_mem_wdata = d_wdata;
            end else if (e_i_gnt) begin
                e_mem_addr = i_addr;
            end
        end
    end

    always @(posedge clk) begin
        if (reset) begin
            resp_cyc <= -1;
            streak   <= 0;
        end else begin
            if (e_i_gnt || (e_d_gnt && !d_we)) begin
                resp_cyc   <= cyc + LAT;
                resp_own_d <= e_d_gnt;
                resp_addr  <= e_d_gnt ? d_addr : i_addr;
            end else if (resp_cyc == cyc) begin
                resp_cyc <= -1;
            end
            if (e_i_gnt) streak <= 0;
            else if (e_d_gnt && i_req && streak < LIMIT) streak <= streak + 1;
        end
        cyc <= cyc + 1;
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b1;
        i_addr = 32'h4; d_addr = 32'h8; d_wdata = 32'h77;
        repeat (3) begin
            @(negedge clk); #1;
            n_cmp++;
            if ({i_gnt, d_gnt, i_rvalid, d_rvalid, busy, mem_we} !== 6'b0) begin
                n_err++; $display("FAIL reset_ctl: got %b want 000000", {i_gnt, d_gnt, i_rvalid, d_rvalid, busy, mem_we});
            end
            n_cmp++;
            if (mem_addr !== 32'h0) begin
                n_err++; $display("FAIL reset_addr: got %h want 00000000", mem_addr);
            end
        end
        @(negedge clk);
        reset = 1'b0; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        #1;
        n_cmp++;
        if ({i_gnt, d_gnt, busy, mem_we} !== 4'b0) begin
            n_err++; $display("FAIL post_reset_idle: got %b want 0000", {i_gnt, d_gnt, busy, mem_we});
        end
    endtask

    task automatic test_lone_fetch();
        @(negedge clk);
        i_req = 1'b1; i_addr = 32'h10; d_req = 1'b0;
        #1;
        n_cmp++;
        if ({i_gnt, d_gnt, mem_we, mem_addr} !== {3'b100, 32'h10}) begin
            n_err++; $display("FAIL fetch_grant: got %b/%h want 100/00000010", {i_gnt, d_gnt, mem_we}, mem_addr);
        end
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            i_req = 1'b0;
            #1;
            n_cmp++;
            if ({i_rvalid, d_rvalid, busy} !== {(k == LAT), 1'b0, (k <= LAT)}) begin
                n_err++; $display("FAIL fetch_wait%0d: got %b want %b", k, {i_rvalid, d_rvalid, busy}, {(k == LAT), 1'b0, (k <= LAT)});
            end
            if (k == LAT) begin
                n_cmp++;
                if (i_rdata !== rom(32'h10)) begin
                    n_err++; $display("FAIL fetch_rdata: got %h want %h", i_rdata, rom(32'h10));
                end
            end
        end
    endtask

    task automatic test_store();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'h55; i_req = 1'b0;
        #1;
        n_cmp++;
        if ({d_gnt, i_gnt, mem_we, busy, mem_addr, mem_wdata} !== {4'b1010, 32'h20, 32'h55}) begin
            n_err++; $display("FAIL store_grant: got %b/%h/%h want 1010/00000020/00000055", {d_gnt, i_gnt, mem_we, busy}, mem_addr, mem_wdata);
        end
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            d_req = 1'b0; d_we = 1'b0;
            #1;
            n_cmp++;
            if ({d_rvalid, busy} !== 2'b00) begin
                n_err++; $display("FAIL store_quiet%0d: got %b want 00", k, {d_rvalid, busy});
            end
        end
    endtask

    task automatic test_read_window();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; i_req = 1'b0;
        #1;
        n_cmp++;
        if (d_gnt !== 1'b1) begin
            n_err++; $display("FAIL window_load_gnt: got %b want 1", d_gnt);
        end
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            d_req = 1'b0; i_req = 1'b1; i_addr = 32'h80;
            #1;
            n_cmp++;
            if ({busy, i_gnt, d_rvalid} !== {1'b1, (k == LAT), (k == LAT)}) begin
                n_err++; $display("FAIL window_wait%0d: got %b want %b", k, {busy, i_gnt, d_rvalid}, {1'b1, (k == LAT), (k == LAT)});
            end
        end
        n_cmp++;
        if (d_rdata !== rom(32'h40)) begin
            n_err++; $display("FAIL window_d_rdata: got %h want %h", d_rdata, rom(32'h40));
        end
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            i_req = 1'b0;
            #1;
            n_cmp++;
            if ({busy, i_rvalid, d_rvalid} !== {1'b1, (k == LAT), 1'b0}) begin
                n_err++; $display("FAIL window_fetch%0d: got %b want %b", k, {busy, i_rvalid, d_rvalid}, {1'b1, (k == LAT), 1'b0});
            end
        end
        n_cmp++;
        if (i_rdata !== rom(32'h80)) begin
            n_err++; $display("FAIL window_i_rdata: got %h want %h", i_rdata, rom(32'h80));
        end
        idle(1);
    endtask

    // Both requesters always asking for loads; starting from a clear streak
    // every fifth grant must go to I.
    task automatic test_starvation(input int n);
        int          k, budget;
        logic        won_d, prev_d, bump_i, bump_d;
        logic [31:0] prev_addr, got;
        k = 0; budget = n * LAT + 4; prev_d = 1'b0; prev_addr = 32'h0;
        bump_i = 1'b0; bump_d = 1'b0;
        i_addr = 32'h600; d_addr = 32'h200;
        while (k < n && budget > 0) begin
            @(negedge clk);
            budget--;
            i_req = 1'b1; d_req = 1'b1; d_we = 1'b0;
            if (bump_i) i_addr = i_addr + 32'h4;
            if (bump_d) d_addr = d_addr + 32'h4;
            bump_i = 1'b0; bump_d = 1'b0;
            #1;
            if (i_gnt || d_gnt) begin
                won_d = ((k % 5) != 4);
                n_cmp++;
                if ({i_gnt, d_gnt} !== {!won_d, won_d}) begin
                    n_err++; $display("FAIL starve_order%0d: got i/d %b want %b", k, {i_gnt, d_gnt}, {!won_d, won_d});
                end
                if (k > 0) begin
                    n_cmp++;
                    got = prev_d ? d_rdata : i_rdata;
                    if ({i_rvalid, d_rvalid, got} !== {!prev_d, prev_d, rom(prev_addr)}) begin
                        n_err++; $display("FAIL starve_resp%0d: got %b/%h want %b/%h", k, {i_rvalid, d_rvalid}, got, {!prev_d, prev_d}, rom(prev_addr));
                    end
                end
                prev_d    = d_gnt;
                prev_addr = d_gnt ? d_addr : i_addr;
                bump_d    = d_gnt;
                bump_i    = i_gnt;
                k++;
            end
        end
        n_cmp++;
        if (k != n) begin
            n_err++; $display("FAIL starve_timeout: got %0d grants want %0d", k, n);
        end
        idle(LAT + 1);
    endtask

    task automatic test_lone_i_then_contest();
        for (int f = 0; f < 3; f++) begin
            @(negedge clk);
            i_req = 1'b1; i_addr = 32'h900 + 32'(f * 4); d_req = 1'b0;
            #1;
            n_cmp++;
            if ({i_gnt, d_gnt} !== 2'b10) begin
                n_err++; $display("FAIL lone_i%0d: got %b want 10", f, {i_gnt, d_gnt});
            end
            idle(LAT);
        end
        @(negedge clk);
        i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_addr = 32'hA00;
        #1;
        n_cmp++;
        if ({i_gnt, d_gnt} !== 2'b01) begin
            n_err++; $display("FAIL lone_i_contest: got %b want 01", {i_gnt, d_gnt});
        end
        idle(LAT + 1);
    endtask

    task automatic test_reset_mid_read();
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h300; i_req = 1'b1; i_addr = 32'h304;
        #1;
        n_cmp++;
        if ({i_gnt, d_gnt} !== 2'b01) begin
            n_err++; $display("FAIL midrst_load: got %b want 01", {i_gnt, d_gnt});
        end
        @(negedge clk);
        reset = 1'b1; d_req = 1'b0; i_req = 1'b0;
        #1;
        n_cmp++;
        if ({busy, d_rvalid, i_gnt, d_gnt} !== 4'b0) begin
            n_err++; $display("FAIL midrst_hold: got %b want 0000", {busy, d_rvalid, i_gnt, d_gnt});
        end
        @(negedge clk);
        reset = 1'b0; d_req = 1'b1; d_we = 1'b1; d_addr = 32'h308; d_wdata = 32'h1234;
        #1;
        n_cmp++;
        if ({d_gnt, mem_we, busy} !== 3'b110) begin
            n_err++; $display("FAIL midrst_first: got %b want 110", {d_gnt, mem_we, busy});
        end
        for (int k = 1; k <= LAT + 1; k++) begin
            @(negedge clk);
            d_req = 1'b0; d_we = 1'b0;
            #1;
            n_cmp++;
            if ({d_rvalid, busy} !== 2'b00) begin
                n_err++; $display("FAIL midrst_drop%0d: got %b want 00", k, {d_rvalid, busy});
            end
        end
        test_starvation(5);
    endtask

    // Protocol-respecting random traffic with occasional resets.
    task automatic test_random(input int ncyc);
        logic i_free, d_free;
        i_free = 1'b1; d_free = 1'b1;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            reset = ($urandom_range(0, 49) == 0);
            if (i_free) begin
                i_req = 1'($urandom_range(0, 1)); i_addr = $urandom;
            end
            if (d_free) begin
                d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
                d_addr = $urandom; d_wdata = $urandom;
            end
            #1;
            n_cmp++;
            if ({i_gnt, d_gnt, i_rvalid, d_rvalid, busy, mem_we} !== {e_i_gnt, e_d_gnt, e_i_rv, e_d_rv, e_busy, e_mem_we}) begin
                n_err++; $display("FAIL rand_ctl@%0d: got %b want %b", c, {i_gnt, d_gnt, i_rvalid, d_rvalid, busy, mem_we}, {e_i_gnt, e_d_gnt, e_i_rv, e_d_rv, e_busy, e_mem_we});
            end
            n_cmp++;
            if (mem_addr !== e_mem_addr) begin
                n_err++; $display("FAIL rand_addr@%0d: got %h want %h", c, mem_addr, e_mem_addr);
            end
            if (e_mem_we) begin
                n_cmp++;
                if (mem_wdata !== e_mem_wdata) begin
                    n_err++; $display("FAIL rand_wdata@%0d: got %h want %h", c, mem_wdata, e_mem_wdata);
                end
            end
            if (e_i_rv) begin
                n_cmp++;
                if (i_rdata !== e_rdata) begin
                    n_err++; $display("FAIL rand_i_rdata@%0d: got %h want %h", c, i_rdata, e_rdata);
                end
            end
            if (e_d_rv) begin
                n_cmp++;
                if (d_rdata !== e_rdata) begin
                    n_err++; $display("FAIL rand_d_rdata@%0d: got %h want %h", c, d_rdata, e_rdata);
                end
            end
            i_free = !i_req || e_i_gnt;
            d_free = !d_req || e_d_gnt;
        end
        @(negedge clk);
        reset = 1'b0;
        idle(LAT + 1);
    endtask

    initial begin
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = 32'h0; d_addr = 32'h0; d_wdata = 32'h0;
        test_reset();
        test_lone_fetch();
        test_store();
        test_read_window();
        test_starvation(10);
        test_lone_i_then_contest();
        test_reset_mid_read();
        test_random(400);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
